// File: rtl/gate_tester.sv
// Exhaustive tester for a 2-input gate: drives all four input vectors, compares against TRUTH_TABLE.
// Optional first-mismatch capture on fail_vec is enabled by defining GATE_TESTER_FIRSTFAIL_EN.
module gate_tester #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
  parameter int         SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       drive_a,
  output logic       drive_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] settle;
  logic       mism;

  assign mism = (dut_out != TRUTH_TABLE[vec]);

  // Outputs are registered and updated together with the state transition,
  // so drive/busy/done always line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vec       <= 2'b00;
      settle    <= 4'd0;
      drive_a   <= 1'b0;
      drive_b   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state              <= S_DRIVE;
            vec                <= 2'b00;
            settle             <= 4'd0;
            err_count          <= 3'd0;
            pass               <= 1'b0;
            busy               <= 1'b1;
            {drive_a, drive_b} <= 2'b00;
          end
        end
        S_DRIVE: begin
          if (settle == SETTLE_LAST) begin
            settle <= 4'd0;
            state  <= S_SAMPLE;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        S_SAMPLE: begin
          if (mism) err_count <= err_count + 3'd1;
          if (vec == 2'b11) begin
            state              <= S_DONE;
            busy               <= 1'b0;
            done               <= 1'b1;
            {drive_a, drive_b} <= 2'b00;
            // final sample must count towards the verdict
            pass               <= (err_count == 3'd0) && !mism;
          end else begin
            vec                <= vec + 2'd1;
            state              <= S_DRIVE;
            {drive_a, drive_b} <= vec + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GATE_TESTER_FIRSTFAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fail_vec <= 2'b00;
    else if (state == S_IDLE && start)
      fail_vec <= 2'b00;
    else if (state == S_SAMPLE && mism && err_count == 3'd0)
      fail_vec <= vec;
  end
`else
  assign fail_vec = 2'b00;
`endif

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 Parameter TRUTH_TABLE, default 4'b0111 (NAND), expected DUT output indexed by {drive_a,drive_b}.
REQ-002 Parameter SETTLE_CYCLES, default 1, legal range 1..15: cycles each vector is held before sampling.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a test run; accepted only in IDLE.
REQ-006 dut_out  input  1  response of the 2-input gate under test.
REQ-007 drive_a  output  1  first gate input stimulus.
REQ-008 drive_b  output  1  second gate input stimulus.
REQ-009 busy  output  1  high in DRIVE and SAMPLE states.
REQ-010 done  output  1  one-cycle pulse at end of run.
REQ-011 pass  output  1  run result: 1 = zero mismatches.
REQ-012 err_count  output  3  number of mismatching vectors in last run (0..4).
REQ-013 fail_vec  output  2  {a,b} of first mismatching vector in last run.

Function
REQ-014 FSM states IDLE, DRIVE, SAMPLE, DONE; 2-bit vector counter vec.
REQ-015 IDLE: start=1 at an edge -> DRIVE, vec=0, err_count=0, pass=0, fail_vec=0.
REQ-016 {drive_a,drive_b} = vec in DRIVE and SAMPLE; 2'b00 in IDLE and DONE.
REQ-017 DRIVE held exactly SETTLE_CYCLES cycles (internal settle counter), then -> SAMPLE.
REQ-018 SAMPLE (one cycle): mismatch if dut_out != TRUTH_TABLE[vec]; on mismatch err_count increments by 1 (no saturation needed, max 4).
REQ-019 SAMPLE: vec!=3 -> vec+1, DRIVE; vec==3 -> DONE.
REQ-020 DONE (one cycle): done=1; pass=1 iff final err_count==0 (including the vec==3 sample); -> IDLE.
REQ-021 Latency: done asserted exactly 4*(SETTLE_CYCLES+1) cycles after the edge that accepted start (8 for default).
REQ-022 pass, err_count, fail_vec hold their values in IDLE until the next accepted start.
REQ-023 start while busy or in DONE: ignored, no restart, no effect on results.
REQ-024 start held high continuously: new run accepted on first IDLE cycle after DONE.
REQ-025 dut_out sampled only in SAMPLE; its value in any other state has no effect.

Reset
REQ-026 rst_n low: immediately (asynchronously) state=IDLE, vec=0, settle counter=0.
REQ-027 rst_n low: drive_a=0, drive_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-028 Reset mid-run aborts the run; no done pulse; first start after rst_n rises begins fresh at vec=0.

Configuration
REQ-029 Macro GATE_TESTER_FIRSTFAIL_EN defined: fail_vec captures vec at the first mismatch of a run, later mismatches do not overwrite.
REQ-030 Macro undefined: no capture logic; fail_vec port present and tied to 2'b00; all other behaviour identical.

Verification
REQ-031 TRUTH_TABLE=4'b0111, DUT=ideal NAND, start pulse -> drive sequence 00,01,10,11; done at cycle 8; pass=1, err_count=0.
REQ-032 TRUTH_TABLE=4'b0111, DUT=NAND followed by NAND-as-inverter (AND), macro on -> err_count=4, pass=0, fail_vec=2'b00.
REQ-033 TRUTH_TABLE=4'b0111, dut_out stuck at 1, macro on -> err_count=1, pass=0, fail_vec=2'b11; macro off -> fail_vec=2'b00.
REQ-034 SETTLE_CYCLES=3, ideal NAND -> each vector held 3 cycles before sample; done at cycle 16; second start pulse at cycle 5 ignored.
REQ-035 rst_n low at cycle 4 of run with stuck-at-1 DUT -> all outputs 0 same cycle, no done; new start after release -> full run, done 8 cycles later.
